// File: rtl/conv_out_requant_if.sv
// conv_out_requant_if: y input stream, z output stream and debug counter of the requantizer
interface conv_out_requant_if;
  logic signed [17:0] s_data_in_y;
  logic               s_valid_y;
  logic               s_ready_y;
  logic        [7:0]  m_data_out_z;
  logic               m_valid_z;
  logic               m_ready_z;
  logic               m_last_z;
  logic        [7:0]  sat_count;
  modport slave (
    input  s_data_in_y, s_valid_y, m_ready_z,
    output s_ready_y, m_data_out_z, m_valid_z, m_last_z, sat_count
  );
  modport master (
    output s_data_in_y, s_valid_y, m_ready_z,
    input  s_ready_y, m_data_out_z, m_valid_z, m_last_z, sat_count
  );
endinterface

// File: rtl/conv_out_requant.sv
// conv_out_requant: round-shift, optional ReLU, 8-bit saturation, FIFO-buffered output with vector last flag
module conv_out_requant #(
  parameter int OUT_LEN  = 5,
  parameter int DEPTH    = 4,
  parameter int LOGDEPTH = 2,
  parameter int SHIFT    = 4,
  parameter int RELU     = 1
) (
  input logic clk,
  input logic reset,
  conv_out_requant_if.slave bus
);
  localparam int PW = OUT_LEN > 1 ? $clog2(OUT_LEN) : 1;
  localparam logic signed [18:0] RND = SHIFT > 0 ? 19'sd1 <<< (SHIFT > 0 ? SHIFT - 1 : 0) : 19'sd0;
  logic [8:0]          mem_q [DEPTH];
  logic [LOGDEPTH-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LOGDEPTH:0]   cnt_q, cnt_d;
  logic [PW-1:0]       pos_q, pos_d;
  logic [7:0]          sat_q, sat_d;
  logic signed [18:0]  sum, r, rr;
  logic                hi, lo, push, pop, last;
  logic [7:0]          q;
  logic [8:0]          head;
  always_comb begin
    sum  = 19'({bus.s_data_in_y[17], bus.s_data_in_y}) + RND;
    r    = sum >>> SHIFT;
    rr   = (RELU != 0 && r < 0) ? 19'sd0 : r;
    hi   = rr > 19'sd127;
    lo   = rr < -19'sd128;
    q    = hi ? 8'h7f : lo ? 8'h80 : rr[7:0];
    push = bus.s_valid_y && bus.s_ready_y;
    pop  = bus.m_valid_z && bus.m_ready_z;
    last = pos_q == PW'(OUT_LEN - 1);
    wr_d  = push ? (wr_q == LOGDEPTH'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d  = pop ? (rd_q == LOGDEPTH'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d = cnt_q + (LOGDEPTH + 1)'(push) - (LOGDEPTH + 1)'(pop);
    pos_d = push ? (last ? '0 : pos_q + 1'b1) : pos_q;
    sat_d = (push && (hi || lo) && sat_q != 8'hff) ? sat_q + 8'd1 : sat_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      pos_q <= '0;
      sat_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      pos_q <= pos_d;
      sat_q <= sat_d;
    end
  end
  // Storage holds no reset; empty entries are masked at the output.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {last, q};
  end
  assign head             = mem_q[rd_q];
  assign bus.s_ready_y    = !reset && (cnt_q < (LOGDEPTH + 1)'(DEPTH));
  assign bus.m_valid_z    = cnt_q != '0;
  assign bus.m_data_out_z = bus.m_valid_z ? head[7:0] : 8'h00;
  assign bus.m_last_z     = bus.m_valid_z && head[8];
  assign bus.sat_count    = sat_q;
endmodule

// File: tb/tb_conv_out_requant.sv
// tb_conv_out_requant: directed checks of requantization, FIFO backpressure, last tagging and reset
module tb_conv_out_requant;
  logic clk = 0;
  logic reset = 1;
  int checks = 0;
  int errors = 0;
  int sent, got;
  conv_out_requant_if ia ();
  conv_out_requant_if ib ();
  conv_out_requant #(.OUT_LEN(5), .DEPTH(4), .LOGDEPTH(2), .SHIFT(4), .RELU(1)) dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
  conv_out_requant #(.OUT_LEN(5), .DEPTH(4), .LOGDEPTH(2), .SHIFT(4), .RELU(0)) dut_b (.clk(clk), .reset(reset), .bus(ib.slave));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic out_a(input string tag, input int d, input int l);
    chk({tag, "_valid"}, int'(ia.m_valid_z), 1);
    chk({tag, "_data"}, int'($signed(ia.m_data_out_z)), d);
    chk({tag, "_last"}, int'(ia.m_last_z), l);
  endtask
  initial begin
    ia.s_valid_y = 0; ia.s_data_in_y = '0; ia.m_ready_z = 0;
    ib.s_valid_y = 0; ib.s_data_in_y = '0; ib.m_ready_z = 0;
    step();
    chk("rst_ready", int'(ia.s_ready_y), 0);
    chk("rst_valid", int'(ia.m_valid_z), 0);
    chk("rst_data", int'(ia.m_data_out_z), 0);
    chk("rst_last", int'(ia.m_last_z), 0);
    chk("rst_sat", int'(ia.sat_count), 0);
    reset = 0;
    step();
    chk("idle_ready", int'(ia.s_ready_y), 1);
    // Round, ReLU, no clamp; each result visible right after its push edge
    ia.m_ready_z = 1; ia.s_valid_y = 1;
    ia.s_data_in_y = 18'sd1000; step(); out_a("t1_1000", 63, 0);
    ia.s_data_in_y = 18'sd24;   step(); out_a("t1_24", 2, 0);
    ia.s_data_in_y = -18'sd8;   step(); out_a("t1_m8", 0, 0);
    ia.s_data_in_y = -18'sd100; step(); out_a("t1_m100", 0, 0);
    ia.s_valid_y = 0; step();
    chk("t1_empty", int'(ia.m_valid_z), 0);
    chk("t1_sat", int'(ia.sat_count), 0);
    // Positive clamp; 5000 is the fifth push so it carries last
    ia.s_valid_y = 1;
    ia.s_data_in_y = 18'sd5000;   step(); out_a("t2_5000", 127, 1);
    ia.s_data_in_y = 18'sd131071; step(); out_a("t2_max", 127, 0);
    ia.s_valid_y = 0; step();
    chk("t2_sat", int'(ia.sat_count), 2);
    // Negative path without ReLU
    ib.m_ready_z = 1; ib.s_valid_y = 1;
    ib.s_data_in_y = -18'sd100; step();
    chk("t3_m100", int'($signed(ib.m_data_out_z)), -6);
    ib.s_data_in_y = -18'sd5000; step();
    chk("t3_m5000", int'($signed(ib.m_data_out_z)), -128);
    ib.s_data_in_y = -18'sd131072; step();
    chk("t3_min", int'($signed(ib.m_data_out_z)), -128);
    ib.s_valid_y = 0; step();
    chk("t3_sat", int'(ib.sat_count), 2);
    chk("t3_empty", int'(ib.m_valid_z), 0);
    // Fill under backpressure; position is 1 so the 4th entry closes the vector
    ia.m_ready_z = 0;
    for (int i = 1; i <= 4; i++) begin
      ia.s_valid_y = 1; ia.s_data_in_y = 18'(16 * i); step();
    end
    chk("t4_full_ready", int'(ia.s_ready_y), 0);
    out_a("t4_head", 1, 0);
    ia.s_data_in_y = 18'sd80; step(); step();
    chk("t4_hold_ready", int'(ia.s_ready_y), 0);
    out_a("t4_hold", 1, 0);
    ia.m_ready_z = 1; step();
    out_a("t4_o2", 2, 0);
    chk("t4_ready_back", int'(ia.s_ready_y), 1);
    step();
    ia.s_valid_y = 0;
    out_a("t4_o3", 3, 0);
    step(); out_a("t4_o4", 4, 1);
    step(); out_a("t4_o5", 5, 0);
    step();
    chk("t4_empty", int'(ia.m_valid_z), 0);
    chk("t4_sat", int'(ia.sat_count), 2);
    // Restart vector position, then stream 10 with free-running sink
    reset = 1; step(); reset = 0;
    ia.m_ready_z = 1;
    for (int i = 1; i <= 10; i++) begin
      ia.s_valid_y = 1; ia.s_data_in_y = 18'(16 * i); step();
      out_a($sformatf("t5_o%0d", i), i, (i == 5 || i == 10) ? 1 : 0);
    end
    ia.s_valid_y = 0; step();
    chk("t5_empty", int'(ia.m_valid_z), 0);
    // Random sink stalls must not change data/last pairing
    sent = 0; got = 0;
    for (int c = 0; c < 300 && got < 10; c++) begin
      ia.m_ready_z = 1'($urandom_range(0, 1));
      ia.s_valid_y = sent < 10;
      ia.s_data_in_y = 18'(16 * (sent + 1));
      if (ia.m_valid_z && ia.m_ready_z) begin
        chk("t5r_data", int'(ia.m_data_out_z), got + 1);
        chk("t5r_last", int'(ia.m_last_z), ((got + 1) % 5 == 0) ? 1 : 0);
        got++;
      end
      if (ia.s_valid_y && ia.s_ready_y) sent++;
      step();
    end
    chk("t5r_count", got, 10);
    ia.s_valid_y = 0; ia.m_ready_z = 1; step(); step();
    // Mid-vector reset discards buffered data and sat_count
    ia.m_ready_z = 0; ia.s_valid_y = 1;
    ia.s_data_in_y = 18'sd5000; step();
    ia.s_data_in_y = 18'sd32; step();
    ia.s_data_in_y = 18'sd16; step();
    ia.s_valid_y = 0;
    chk("t6_pre_sat", int'(ia.sat_count), 1);
    reset = 1; step();
    chk("t6_rst_valid", int'(ia.m_valid_z), 0);
    chk("t6_rst_ready", int'(ia.s_ready_y), 0);
    chk("t6_rst_sat", int'(ia.sat_count), 0);
    chk("t6_rst_data", int'(ia.m_data_out_z), 0);
    reset = 0; ia.m_ready_z = 1;
    for (int i = 1; i <= 5; i++) begin
      ia.s_valid_y = 1; ia.s_data_in_y = 18'(16 * i); step();
      out_a($sformatf("t6_o%0d", i), i, (i == 5) ? 1 : 0);
    end
    ia.s_valid_y = 0; step();
    chk("t6_empty", int'(ia.m_valid_z), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
